// File: rtl/ball_controller.sv
// Pong ball controller: frame-stepped ball motion with wall bounces, paddle
// hits, scoring, a post-point pause and a first-to-WIN_SCORE game flow.
module ball_controller #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED        = 2,
  parameter int LPAD_FACE    = 20,
  parameter int RPAD_FACE    = 620,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic [11:0] lpad_top,
  input  logic [11:0] lpad_bottom,
  input  logic [11:0] rpad_top,
  input  logic [11:0] rpad_bottom,
  output logic [11:0] ball_top,
  output logic [11:0] ball_bottom,
  output logic [11:0] ball_left,
  output logic [11:0] ball_right,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        point_scored,
  output logic        in_play,
  output logic        game_over
);

  localparam int X_MAX_I = H_ACTIVE - 1 - BALL_SIZE;
  localparam int Y_MAX_I = V_ACTIVE - 1 - BALL_SIZE;
  localparam int X_C_I   = (H_ACTIVE - BALL_SIZE) / 2;
  localparam int Y_C_I   = (V_ACTIVE - BALL_SIZE) / 2;

  // 13-bit copies let position comparisons run without 12-bit wraparound.
  localparam logic [12:0] X_MAX_W = 13'(X_MAX_I);
  localparam logic [12:0] Y_MAX_W = 13'(Y_MAX_I);
  localparam logic [12:0] BS_W    = 13'(BALL_SIZE);
  localparam logic [12:0] SPD_W   = 13'(SPEED);
  localparam logic [12:0] LF_W    = 13'(LPAD_FACE);
  localparam logic [12:0] RF_W    = 13'(RPAD_FACE);

  localparam logic [11:0] X_CEN   = 12'(X_C_I);
  localparam logic [11:0] Y_CEN   = 12'(Y_C_I);
  localparam logic [11:0] Y_LIM   = 12'(Y_MAX_I);
  localparam logic [11:0] SPD     = 12'(SPEED);
  localparam logic [11:0] BS      = 12'(BALL_SIZE);
  localparam logic [11:0] LF_POS  = 12'(LPAD_FACE);
  localparam logic [11:0] RF_POS  = 12'(RPAD_FACE - BALL_SIZE);

  localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_FRAMES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, PLAY, SCORED, OVER} state_t;

  state_t      state, state_nxt;
  logic [11:0] x, y, x_nxt, y_nxt;
  logic        dx, dy, dx_nxt, dy_nxt;
  logic [3:0]  score_left_nxt, score_right_nxt;
  logic [15:0] pause_cnt, pause_nxt;
  logic        point_nxt;

  logic [12:0] x_ext, y_ext;
  logic        lpad_overlap, rpad_overlap;
  logic        left_hit, right_hit, left_miss, right_miss;
  logic [11:0] y_move;
  logic        dy_move;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'd15) ? s : s + 4'd1;
  endfunction

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};

  assign lpad_overlap = (y_ext + BS_W - 13'd1 > {1'b0, lpad_top}) &&
                        (y_ext < {1'b0, lpad_bottom});
  assign rpad_overlap = (y_ext + BS_W - 13'd1 > {1'b0, rpad_top}) &&
                        (y_ext < {1'b0, rpad_bottom});

  // A hit needs the ball to be at or in front of the face now and to cross it this frame.
  assign left_hit   = !dx && (x_ext >= LF_W) && (x_ext < LF_W + SPD_W) && lpad_overlap;
  assign right_hit  = dx && (x_ext + BS_W <= RF_W) &&
                      (x_ext + SPD_W + BS_W > RF_W) && rpad_overlap;
  assign left_miss  = !dx && (x_ext < SPD_W + 13'd1) && !left_hit;
  assign right_miss = dx && (x_ext + SPD_W > X_MAX_W) && !right_hit;

  always_comb begin
    y_move  = y;
    dy_move = dy;
    if (!dy) begin
      if (y_ext < SPD_W + 13'd1) begin
        y_move  = 12'd1;
        dy_move = 1'b1;
      end else begin
        y_move = y - SPD;
      end
    end else if (y_ext + SPD_W > Y_MAX_W) begin
      y_move  = Y_LIM;
      dy_move = 1'b0;
    end else begin
      y_move = y + SPD;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt       = state;
    x_nxt           = x;
    y_nxt           = y;
    dx_nxt          = dx;
    dy_nxt          = dy;
    score_left_nxt  = score_left;
    score_right_nxt = score_right;
    pause_nxt       = pause_cnt;
    point_nxt       = 1'b0;

    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (serve) state_nxt = PLAY;
        end

        PLAY: begin
          if (left_miss || right_miss) begin
            if (left_miss) score_right_nxt = sat_inc(score_right);
            else           score_left_nxt  = sat_inc(score_left);
            point_nxt = 1'b1;
            pause_nxt = 16'd0;
            state_nxt = SCORED;
          end else begin
            y_nxt  = y_move;
            dy_nxt = dy_move;
            if (left_hit) begin
              x_nxt  = LF_POS;
              dx_nxt = 1'b1;
            end else if (right_hit) begin
              x_nxt  = RF_POS;
              dx_nxt = 1'b0;
            end else begin
              x_nxt = dx ? x + SPD : x - SPD;
            end
          end
        end

        SCORED: begin
          if (pause_cnt == PAUSE_LAST) begin
            // dx still points at the side that conceded, since the ball froze on the miss.
            pause_nxt = 16'd0;
            x_nxt     = X_CEN;
            y_nxt     = Y_CEN;
            dy_nxt    = 1'b1;
            state_nxt = (score_left == WIN || score_right == WIN) ? OVER : IDLE;
          end else begin
            pause_nxt = pause_cnt + 16'd1;
          end
        end

        OVER: begin
          if (serve) begin
            score_left_nxt  = 4'd0;
            score_right_nxt = 4'd0;
            state_nxt       = IDLE;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      x            <= X_CEN;
      y            <= Y_CEN;
      dx           <= 1'b1;
      dy           <= 1'b1;
      score_left   <= 4'd0;
      score_right  <= 4'd0;
      pause_cnt    <= 16'd0;
      point_scored <= 1'b0;
    end else begin
      state        <= state_nxt;
      x            <= x_nxt;
      y            <= y_nxt;
      dx           <= dx_nxt;
      dy           <= dy_nxt;
      score_left   <= score_left_nxt;
      score_right  <= score_right_nxt;
      pause_cnt    <= pause_nxt;
      point_scored <= point_nxt;
    end
  end

  assign ball_left   = x - 12'd1;
  assign ball_right  = x + BS;
  assign ball_top    = y - 12'd1;
  assign ball_bottom = y + BS;
  assign in_play     = (state == PLAY);
  assign game_over   = (state == OVER);

endmodule

// File: tb/tb_ball_controller.sv
// Bench for ball_controller: directed vector table, game-over sequence and
// randomized frames checked against a frame-level behavioural model.
module tb_ball_controller;

  localparam int X_MAX = 640 - 1 - 8;
  localparam int Y_MAX = 480 - 1 - 8;
  localparam int X_C   = (640 - 8) / 2;
  localparam int Y_C   = (480 - 8) / 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        serve = 1'b0;
  logic [11:0] lpad_top = '0, lpad_bottom = '0, rpad_top = '0, rpad_bottom = '0;
  logic [11:0] ball_top, ball_bottom, ball_left, ball_right;
  logic [3:0]  score_left, score_right;
  logic        point_scored, in_play, game_over;

  int n_checks = 0;
  int n_errors = 0;

  ball_controller dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .serve(serve),
    .lpad_top(lpad_top), .lpad_bottom(lpad_bottom),
    .rpad_top(rpad_top), .rpad_bottom(rpad_bottom),
    .ball_top(ball_top), .ball_bottom(ball_bottom),
    .ball_left(ball_left), .ball_right(ball_right),
    .score_left(score_left), .score_right(score_right),
    .point_scored(point_scored), .in_play(in_play), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input bit s);
    @(negedge clk);
    frame_tick = 1'b1;
    serve      = s;
    @(negedge clk);
    frame_tick = 1'b0;
    serve      = 1'b0;
  endtask

  // Reset is asserted together with a serving frame tick, which it must override.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; frame_tick = 1'b1; serve = 1'b1;
    @(negedge clk);
    reset_n = 1'b1; frame_tick = 1'b0; serve = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    bit rst; int n; bit srv; int rt; int rb;
    int x; int y; bit ip; int sl; int sr; bit pt; bit ov;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, int n, bit srv, int rt, int rb, int x, int y,
                              bit ip, int sl, int sr, bit pt, bit ov);
    vec_t v;
    v.rst = rst; v.n = n; v.srv = srv; v.rt = rt; v.rb = rb;
    v.x = x; v.y = y; v.ip = ip; v.sl = sl; v.sr = sr; v.pt = pt; v.ov = ov;
    vecs.push_back(v);
  endfunction

  task automatic expect_state(input string tag, input int x, input int y, input bit ip,
                              input int sl, input int sr, input bit pt, input bit ov);
    check({tag, ".left"},   64'(ball_left),    64'(x - 1));
    check({tag, ".right"},  64'(ball_right),   64'(x + 8));
    check({tag, ".top"},    64'(ball_top),     64'(y - 1));
    check({tag, ".bottom"}, 64'(ball_bottom),  64'(y + 8));
    check({tag, ".in_play"},64'(in_play),      64'(ip));
    check({tag, ".score_l"},64'(score_left),   64'(sl));
    check({tag, ".score_r"},64'(score_right),  64'(sr));
    check({tag, ".point"},  64'(point_scored), 64'(pt));
    check({tag, ".over"},   64'(game_over),    64'(ov));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    rpad_top    = 12'(v.rt);
    rpad_bottom = 12'(v.rb);
    if (v.rst) do_reset();
    repeat (v.n) tick(v.srv);
    expect_state($sformatf("vec%0d", idx), v.x, v.y, v.ip, v.sl, v.sr, v.pt, v.ov);
    if (v.pt) begin
      @(negedge clk);
      check($sformatf("vec%0d.pulse_clear", idx), 64'(point_scored), 64'd0);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_x, m_y, m_sl, m_sr, m_pause;
  bit m_dx, m_dy, m_play, m_over, m_point;

  function automatic void model_reset();
    m_x = X_C; m_y = Y_C; m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0;
    m_pause = 0; m_play = 0; m_over = 0; m_point = 0;
  endfunction

  function automatic void model_frame(bit srv, int lt, int lb, int rt, int rb);
    int nx, ny;
    bit lov, rov, lhit, rhit;
    m_point = 0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin
        m_x = X_C; m_y = Y_C; m_dy = 1;
        if (m_sl == 9 || m_sr == 9) m_over = 1;
      end
    end else if (m_over) begin
      if (srv) begin m_sl = 0; m_sr = 0; m_over = 0; end
    end else if (!m_play) begin
      if (srv) m_play = 1;
    end else begin
      nx   = m_dx ? m_x + 2 : m_x - 2;
      lov  = (m_y + 7 > lt) && (m_y < lb);
      rov  = (m_y + 7 > rt) && (m_y < rb);
      lhit = !m_dx && m_x >= 20 && nx < 20 && lov;
      rhit = m_dx && m_x + 8 <= 620 && nx + 8 > 620 && rov;
      if ((!m_dx && nx < 1 && !lhit) || (m_dx && nx > X_MAX && !rhit)) begin
        if (m_dx) m_sl = (m_sl < 15) ? m_sl + 1 : 15;
        else      m_sr = (m_sr < 15) ? m_sr + 1 : 15;
        m_play = 0; m_pause = 60; m_point = 1;
      end else begin
        ny = m_dy ? m_y + 2 : m_y - 2;
        if (ny < 1)          begin ny = 1;     m_dy = 1; end
        else if (ny > Y_MAX) begin ny = Y_MAX; m_dy = 0; end
        m_y = ny;
        if (lhit)      begin m_x = 20;  m_dx = 1; end
        else if (rhit) begin m_x = 612; m_dx = 0; end
        else           m_x = nx;
      end
    end
  endfunction

  initial begin
    int lt, lb, rt, rb, gap;
    bit srv;
    logic [63:0] act, exp;

    // Serve: right wall miss after 158 play frames, pause, recentre.
    add(1, 0,   0, 0,   40,  316, 236, 0, 0, 0, 0, 0);
    add(0, 1,   0, 0,   40,  316, 236, 0, 0, 0, 0, 0);
    add(0, 1,   1, 0,   40,  316, 236, 1, 0, 0, 0, 0);
    add(0, 1,   0, 0,   40,  318, 238, 1, 0, 0, 0, 0);
    add(0, 116, 0, 0,   40,  550, 470, 1, 0, 0, 0, 0);
    add(0, 1,   0, 0,   40,  552, 471, 1, 0, 0, 0, 0);
    add(0, 39,  0, 0,   40,  630, 393, 1, 0, 0, 0, 0);
    add(0, 1,   0, 0,   40,  630, 393, 0, 1, 0, 1, 0);
    add(0, 59,  0, 0,   40,  630, 393, 0, 1, 0, 0, 0);
    add(0, 1,   0, 0,   40,  316, 236, 0, 1, 0, 0, 0);
    add(0, 1,   1, 0,   40,  316, 236, 1, 1, 0, 0, 0);
    add(0, 1,   0, 0,   40,  318, 238, 1, 1, 0, 0, 0);
    // Reset mid-play, then a right-paddle return.
    add(1, 0,   0, 380, 460, 316, 236, 0, 0, 0, 0, 0);
    add(0, 1,   1, 380, 460, 316, 236, 1, 0, 0, 0, 0);
    add(0, 148, 0, 380, 460, 612, 411, 1, 0, 0, 0, 0);
    add(0, 1,   0, 380, 460, 612, 409, 1, 0, 0, 0, 0);
    add(0, 1,   0, 380, 460, 610, 407, 1, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Serve held without frame_tick must be ignored.
    do_reset();
    @(negedge clk);
    serve = 1'b1;
    repeat (5) @(negedge clk);
    serve = 1'b0;
    check("serve_no_tick.in_play", 64'(in_play),   64'd0);
    check("serve_no_tick.left",    64'(ball_left), 64'd315);

    // Play nine identical rallies lost by the right side to reach game over.
    do_reset();
    rpad_top = 12'd0; rpad_bottom = 12'd40;
    for (int r = 1; r <= 9; r++) begin
      tick(1'b1);
      repeat (158) tick(1'b0);
      repeat (60) tick(1'b0);
      if (r == 8) expect_state("rally8", 316, 236, 0, 8, 0, 0, 0);
    end
    expect_state("game_over", 316, 236, 0, 9, 0, 0, 1);
    @(negedge clk);
    serve = 1'b1;
    repeat (4) @(negedge clk);
    serve = 1'b0;
    check("over_serve_no_tick", 64'(game_over), 64'd1);
    tick(1'b1);
    expect_state("restart", 316, 236, 0, 0, 0, 0, 0);
    tick(1'b1);
    check("restart_serve.in_play", 64'(in_play), 64'd1);

    // Randomized frames against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      lt  = $urandom_range(0, 470); lb = lt + $urandom_range(0, 160);
      rt  = $urandom_range(0, 470); rb = rt + $urandom_range(0, 160);
      srv = ($urandom_range(0, 3) == 0);
      lpad_top = 12'(lt); lpad_bottom = 12'(lb);
      rpad_top = 12'(rt); rpad_bottom = 12'(rb);
      tick(srv);
      model_frame(srv, lt, lb, rt, rb);
      act = {5'd0, ball_left, ball_right, ball_top, ball_bottom,
             score_left, score_right, point_scored, in_play, game_over};
      exp = {5'd0, 12'(m_x - 1), 12'(m_x + 8), 12'(m_y - 1), 12'(m_y + 8),
             4'(m_sl), 4'(m_sr), m_point, m_play, m_over};
      check($sformatf("rand%0d", i), act, exp);
      if (m_point) begin
        @(negedge clk);
        check($sformatf("rand%0d.pulse_clear", i), 64'(point_scored), 64'd0);
      end
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        serve = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      serve = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
